uart_tx_feeder: RTL

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

---
 rtl/uart_tx_feeder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: a small synchronous FIFO that buffers producer words and
// hands them one at a time to a uart_tx. Each handoff is a single-cycle
// load strobe. The next word is offered only after uart_tx has gone busy
// and then come back to ready.
//
// DEPTH must be a power of two (minimum 2). The pointers wrap by natural
// overflow, and the occupancy counter is the only source of full and empty.
module uart_tx_feeder #(
    parameter int WORD_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic                    wr_valid,
    input  logic [WORD_WIDTH-1:0]   wr_data,
    output logic                    wr_ready,
    input  logic                    tx_ready,
    output logic                    tx_data_valid,
    output logic [WORD_WIDTH-1:0]   tx_data_in,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty,
    output logic                    overflow,
    input  logic                    ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t                 state;
    logic [WORD_WIDTH-1:0]  mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic                   push;
    logic                   pop;

    // Status flags are decoded from the occupancy counter alone.
    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign wr_ready = !full;

    // A write is taken only when there is room. A pop happens only from IDLE,
    // when a word is waiting and uart_tx reports it can take one.
    assign push = wr_valid && !full;
    assign pop  = (state == IDLE) && !empty && tx_ready;

    // Word storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Write pointer, occupancy count and the sticky overflow flag.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // A refused write sets the flag, and setting beats a coincident clear.
            if (wr_valid && full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Handoff FSM: pop a word, then wait for uart_tx to go busy and come back.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            rd_ptr        <= '0;
            tx_data_valid <= 1'b0;
            tx_data_in    <= '0;
        end else begin
            tx_data_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data_in    <= mem[rd_ptr];
                        tx_data_valid <= 1'b1;
                        rd_ptr        <= rd_ptr + AW'(1);
                        state         <= WAIT_BUSY;
                    end
                end

                WAIT_BUSY: begin
                    if (!tx_ready) begin
                        state <= WAIT_DONE;
                    end
                end

                WAIT_DONE: begin
                    if (tx_ready) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
